// File: rtl/strobe_period_checker.sv
// Strobe period checker: measures the interval between same-domain strobes, locks after
// LOCK_COUNT matching intervals and flags early/missing strobes. Optional err_count via STROBE_PERIOD_ERRCNT_EN.
module strobe_period_checker #(
  parameter int unsigned DIV        = 3,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned CW         = 8
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          strobe,
  output logic          lock,
  output logic          err,
  output logic [CW-1:0] period,
  output logic          period_valid
`ifdef STROBE_PERIOD_ERRCNT_EN
  ,
  output logic [7:0]    err_count
`endif
);

  localparam int unsigned MW = 4;
  localparam logic [CW-1:0] DIV_C  = CW'(DIV);
  localparam logic [CW-1:0] G_MAX  = {CW{1'b1}};
  localparam logic [MW-1:0] LOCK_C = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2,
    ERROR   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] g;
  logic [MW-1:0] match_cnt;
  logic [MW-1:0] match_nxt;
  logic          g_hit;

  assign g_hit = (g == DIV_C);

  // Next-state and match-count decode
  always_comb begin
    state_nxt = state;
    match_nxt = match_cnt;
    case (state)
      IDLE: begin
        if (strobe) begin
          state_nxt = MEASURE;
          match_nxt = '0;
        end
      end
      MEASURE: begin
        if (strobe) begin
          if (g_hit) begin
            match_nxt = match_cnt + MW'(1);
            if (match_nxt == LOCK_C) state_nxt = LOCKED;
          end else begin
            match_nxt = '0;
          end
        end
      end
      LOCKED: begin
        // a strobe off the expected slot, or none on it, breaks lock
        if (strobe) begin
          if (!g_hit) state_nxt = ERROR;
        end else if (g_hit) begin
          state_nxt = ERROR;
        end
      end
      ERROR: begin
        if (strobe) begin
          state_nxt = MEASURE;
          match_nxt = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
        match_nxt = '0;
      end
    endcase
  end

  // State, gap counter and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      match_cnt    <= '0;
      g            <= '0;
      lock         <= 1'b0;
      err          <= 1'b0;
      period       <= '0;
      period_valid <= 1'b0;
    end else begin
      state        <= state_nxt;
      match_cnt    <= match_nxt;
      lock         <= (state_nxt == LOCKED);
      err          <= (state_nxt == ERROR);
      period_valid <= strobe && (state != IDLE);
      if (strobe) begin
        g <= CW'(1);
        if (state != IDLE) period <= g;
      end else if (g != G_MAX) begin
        g <= g + CW'(1);
      end
    end
  end

`ifdef STROBE_PERIOD_ERRCNT_EN
  // Saturating count of lock losses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_count <= '0;
    end else if ((state == LOCKED) && (state_nxt == ERROR) && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_strobe_period_checker.sv
// Bench for strobe_period_checker: three instances (default, CW=4, DIV=1) driven from a vector table
// and hand sequences; expected outputs go through a scoreboard queue.
module tb_strobe_period_checker;

  typedef struct {
    int unsigned sel;
    logic        s;
    int          rep;
    logic        l;
    logic        e;
    logic [7:0]  p;
    logic        v;
  } vec_t;

  typedef struct {
    logic       l;
    logic       e;
    logic [7:0] p;
    logic       v;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic s0 = 1'b0, s1 = 1'b0, s2 = 1'b0;

  logic       lock0, err0, pv0;
  logic [7:0] period0;
  logic       lock1, err1, pv1;
  logic [3:0] period1;
  logic       lock2, err2, pv2;
  logic [7:0] period2;
`ifdef STROBE_PERIOD_ERRCNT_EN
  logic [7:0] ec0, ec1, ec2;
`endif

  int unsigned total = 0;
  int unsigned passed = 0;
  exp_t sb[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  strobe_period_checker #(.DIV(3), .LOCK_COUNT(4), .CW(8)) dut (
    .clk(clk), .reset_n(reset_n), .strobe(s0), .lock(lock0), .err(err0),
    .period(period0), .period_valid(pv0)
`ifdef STROBE_PERIOD_ERRCNT_EN
    , .err_count(ec0)
`endif
  );

  strobe_period_checker #(.DIV(3), .LOCK_COUNT(4), .CW(4)) dut4 (
    .clk(clk), .reset_n(reset_n), .strobe(s1), .lock(lock1), .err(err1),
    .period(period1), .period_valid(pv1)
`ifdef STROBE_PERIOD_ERRCNT_EN
    , .err_count(ec1)
`endif
  );

  strobe_period_checker #(.DIV(1), .LOCK_COUNT(2), .CW(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .strobe(s2), .lock(lock2), .err(err2),
    .period(period2), .period_valid(pv2)
`ifdef STROBE_PERIOD_ERRCNT_EN
    , .err_count(ec2)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic cmp(input int unsigned sel, input exp_t e, input string tag);
    logic l, er, v;
    logic [7:0] p;
    case (sel)
      0: begin l = lock0; er = err0; v = pv0; p = period0; end
      1: begin l = lock1; er = err1; v = pv1; p = {4'd0, period1}; end
      default: begin l = lock2; er = err2; v = pv2; p = period2; end
    endcase
    check({tag, ".lock"}, 32'(l), 32'(e.l));
    check({tag, ".err"}, 32'(er), 32'(e.e));
    check({tag, ".period"}, 32'(p), 32'(e.p));
    check({tag, ".period_valid"}, 32'(v), 32'(e.v));
  endtask

  task automatic step(input int unsigned sel, input logic s, input exp_t e, input string tag);
    exp_t got;
    s0 = (sel == 0) && s;
    s1 = (sel == 1) && s;
    s2 = (sel == 2) && s;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    cmp(sel, got, tag);
  endtask

  task automatic add(input int unsigned sel, input logic s, input int rep, input logic l,
                     input logic e, input logic [7:0] p, input logic v);
    tbl.push_back('{sel, s, rep, l, e, p, v});
  endtask

  initial begin
    // DIV=1, LOCK_COUNT=2: continuous strobe locks after 3 events, one low cycle errors
    add(2, 1, 1, 0, 0, 8'd0, 0);
    add(2, 1, 1, 0, 0, 8'd1, 1);
    add(2, 1, 2, 1, 0, 8'd1, 1);
    add(2, 0, 1, 0, 1, 8'd1, 0);
    add(2, 1, 1, 0, 0, 8'd2, 1);
    // DIV=3, LOCK_COUNT=4: lock, missing strobe, relock, early strobe, relock
    add(0, 1, 1, 0, 0, 8'd0, 0);
    add(0, 0, 2, 0, 0, 8'd0, 0);
    for (int k = 0; k < 4; k++) begin
      add(0, 1, 1, k == 3, 0, 8'd3, 1);
      if (k < 3) add(0, 0, 2, 0, 0, 8'd3, 0);
    end
    add(0, 0, 2, 1, 0, 8'd3, 0);
    add(0, 0, 2, 0, 1, 8'd3, 0);
    add(0, 1, 1, 0, 0, 8'd5, 1);
    for (int k = 0; k < 4; k++) begin
      add(0, 0, 2, 0, 0, (k == 0) ? 8'd5 : 8'd3, 0);
      add(0, 1, 1, k == 3, 0, 8'd3, 1);
    end
    add(0, 0, 1, 1, 0, 8'd3, 0);
    add(0, 1, 1, 0, 1, 8'd2, 1);
    add(0, 0, 2, 0, 1, 8'd2, 0);
    add(0, 1, 1, 0, 0, 8'd3, 1);
    for (int k = 0; k < 4; k++) begin
      add(0, 0, 2, 0, 0, 8'd3, 0);
      add(0, 1, 1, k == 3, 0, 8'd3, 1);
    end
    add(0, 0, 2, 1, 0, 8'd3, 0);

    // reset held with strobe toggling, then idle after release
    for (int i = 0; i < 3; i++) step(0, logic'(i % 2 == 0), '{0, 0, 8'd0, 0}, $sformatf("rst%0d", i));
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) step(0, 1'b0, '{0, 0, 8'd0, 0}, $sformatf("idle%0d", i));

    for (int i = 0; i < tbl.size(); i++)
      for (int r = 0; r < tbl[i].rep; r++)
        step(tbl[i].sel, tbl[i].s, '{tbl[i].l, tbl[i].e, tbl[i].p, tbl[i].v},
             $sformatf("tbl%0d.%0d", i, r));

`ifdef STROBE_PERIOD_ERRCNT_EN
    check("err_count_2", 32'(ec0), 32'd2);
    step(0, 1'b0, '{0, 1, 8'd3, 0}, "third_loss");
    check("err_count_3", 32'(ec0), 32'd3);
`endif

    // asynchronous reset mid-operation
    reset_n = 1'b0;
    #1;
    check("async_rst.lock", 32'(lock0), 32'd0);
    check("async_rst.err", 32'(err0), 32'd0);
    check("async_rst.period", 32'(period0), 32'd0);
    check("async_rst.pv", 32'(pv0), 32'd0);
`ifdef STROBE_PERIOD_ERRCNT_EN
    check("async_rst.err_count", 32'(ec0), 32'd0);
`endif
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // CW=4: gap counter saturates at 15, then relock from MEASURE
    step(1, 1'b1, '{0, 0, 8'd0, 0}, "sat.first");
    for (int i = 0; i < 20; i++) step(1, 1'b0, '{0, 0, 8'd0, 0}, $sformatf("sat.gap%0d", i));
    step(1, 1'b1, '{0, 0, 8'd15, 1}, "sat.meas");
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 2; i++)
        step(1, 1'b0, '{0, 0, (k == 0) ? 8'd15 : 8'd3, 0}, $sformatf("sat.low%0d_%0d", k, i));
      step(1, 1'b1, '{k == 3, 0, 8'd3, 1}, $sformatf("sat.ev%0d", k));
    end

    if (sb.size() != 0) check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
